// File: rtl/load_store_unit_pkg.sv
// Shared types and lane helpers for the load/store unit and its byte-lane aligner.
package load_store_unit_pkg;

    typedef logic [31:0] t_address;
    typedef logic [31:0] t_data;

    localparam int LSU_MEM_WORDS = 1024;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } t_mem_funct3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_RESP  = 2'd3
    } t_lsu_state;

    // Byte lanes touched across two consecutive words; upper nibble non-zero means crossing.
    function automatic logic [7:0] lanes8(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [7:0] size_mask;
        case (funct3)
            MEM_B, MEM_BU: size_mask = 8'b0000_0001;
            MEM_H, MEM_HU: size_mask = 8'b0000_0011;
            MEM_W:         size_mask = 8'b0000_1111;
            default:       size_mask = 8'b0000_0000;
        endcase
        return size_mask << addr_lo;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response handshake plus the memory data port, as seen by the LSU.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_write;
    logic [2:0] i_req_funct3;
    t_address   i_req_address;
    t_data      i_req_data;
    logic       o_resp_valid;
    logic       i_resp_ready;
    t_data      o_resp_data;
    logic       o_resp_fault;
    t_address   o_mem_address;
    t_data      o_mem_in_data;
    logic [3:0] o_mem_write_mask;
    logic       o_mem_write_en;
    t_data      i_mem_out_data;

    modport slave (
        input  i_req_valid, i_req_write, i_req_funct3, i_req_address, i_req_data,
        input  i_resp_ready, i_mem_out_data,
        output o_req_ready, o_resp_valid, o_resp_data, o_resp_fault,
        output o_mem_address, o_mem_in_data, o_mem_write_mask, o_mem_write_en
    );

    modport master (
        output i_req_valid, i_req_write, i_req_funct3, i_req_address, i_req_data,
        output i_resp_ready, i_mem_out_data,
        input  o_req_ready, o_resp_valid, o_resp_data, o_resp_fault,
        input  o_mem_address, o_mem_in_data, o_mem_write_mask, o_mem_write_en
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: store lane masks/data shifting and load extraction/extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  t_data       data_i,
    input  t_data       lo_i,
    input  t_data       hi_i,
    output logic [7:0]  lanes8_o,
    output logic [63:0] data64_o,
    output t_data       load_o
);

    logic [5:0]  shift;
    logic [63:0] load64;

    assign shift    = {1'b0, addr_lo_i, 3'b000};
    assign lanes8_o = lanes8(funct3_i, addr_lo_i);
    assign data64_o = {32'b0, data_i} << shift;
    assign load64   = {hi_i, lo_i} >> shift;

    always_comb begin
        load_o = '0;
        case (funct3_i)
            MEM_B:   load_o = {{24{load64[7]}}, load64[7:0]};
            MEM_H:   load_o = {{16{load64[15]}}, load64[15:0]};
            MEM_W:   load_o = load64[31:0];
            MEM_BU:  load_o = {24'b0, load64[7:0]};
            MEM_HU:  load_o = {16'b0, load64[15:0]};
            default: load_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer: validates a request, issues one or two word beats, then holds the response.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    load_store_unit_if.slave  bus
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    t_lsu_state  state_q, state_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    t_address    addr_q;
    t_data       data_q;
    t_data       lo_q, hi_q;
    logic        fault_q;

    logic        accept;
    logic        legal_req;
    logic        range_fault;
    logic        fault_req;
    logic [7:0]  req_lanes;
    logic [31:0] req_word0;
    logic [7:0]  lanes;
    logic [63:0] data64;
    t_data       load_val;
    logic        we_raw;
    t_address    word0_addr;

    assign accept    = (state_q == S_IDLE) && bus.i_req_valid;
    assign req_lanes = lanes8(bus.i_req_funct3, bus.i_req_address[1:0]);
    assign req_word0 = {2'b00, bus.i_req_address[31:2]};

    always_comb begin
        legal_req = 1'b0;
        case (bus.i_req_funct3)
            MEM_B, MEM_H, MEM_W: legal_req = 1'b1;
            MEM_BU, MEM_HU:      legal_req = !bus.i_req_write;
            default:             legal_req = 1'b0;
        endcase
    end

    // Both words are range-checked up front so a crossing store never writes half of itself.
    assign range_fault = (req_word0 >= MEM_WORDS_W) ||
                         ((req_lanes[7:4] != 4'b0000) && (req_word0 + 32'd1 >= MEM_WORDS_W));
    assign fault_req   = !legal_req || range_fault;

    lsu_align u_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .data_i    (data_q),
        .lo_i      (lo_q),
        .hi_i      (hi_q),
        .lanes8_o  (lanes),
        .data64_o  (data64),
        .load_o    (load_val)
    );

    assign word0_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= bus.i_req_write;
                funct3_q <= bus.i_req_funct3;
                addr_q   <= bus.i_req_address;
                data_q   <= bus.i_req_data;
                fault_q  <= fault_req;
                lo_q     <= '0;
                hi_q     <= '0;
            end
            if (state_q == S_BEAT0 && !write_q) lo_q <= bus.i_mem_out_data;
            if (state_q == S_BEAT1 && !write_q) hi_q <= bus.i_mem_out_data;
        end
    end

    always_comb begin
        state_d              = state_q;
        bus.o_req_ready      = 1'b0;
        bus.o_resp_valid     = 1'b0;
        bus.o_mem_address    = '0;
        bus.o_mem_in_data    = '0;
        bus.o_mem_write_mask = '0;
        we_raw               = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.o_req_ready = 1'b1;
                if (bus.i_req_valid) state_d = fault_req ? S_RESP : S_BEAT0;
            end
            S_BEAT0: begin
                bus.o_mem_address = word0_addr;
                if (write_q) begin
                    bus.o_mem_in_data    = data64[31:0];
                    bus.o_mem_write_mask = lanes[3:0];
                    we_raw               = (lanes[3:0] != 4'b0000);
                end
                state_d = (lanes[7:4] != 4'b0000) ? S_BEAT1 : S_RESP;
            end
            S_BEAT1: begin
                bus.o_mem_address = word0_addr + 32'd4;
                if (write_q) begin
                    bus.o_mem_in_data    = data64[63:32];
                    bus.o_mem_write_mask = lanes[7:4];
                    we_raw               = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                bus.o_resp_valid = 1'b1;
                if (bus.i_resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_mem_write_en = we_raw && !i_rst;
    assign bus.o_resp_fault   = (state_q == S_RESP) && fault_q;
    assign bus.o_resp_data    = (state_q == S_RESP && !fault_q && !write_q) ? load_val : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory (async read, masked write).
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    int          wr_count = 0;
    logic [31:0] wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic [3:0]  wr_mask [0:63];

    assign bus.i_mem_out_data = mem[bus.o_mem_address[11:2]];

    always @(posedge i_clk) begin
        if (bus.o_mem_write_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_write_mask[b])
                    mem[bus.o_mem_address[11:2]][8*b +: 8] <= bus.o_mem_in_data[8*b +: 8];
            if (wr_count < 64) begin
                wr_addr[wr_count] = bus.o_mem_address;
                wr_data[wr_count] = bus.o_mem_in_data;
                wr_mask[wr_count] = bus.o_mem_write_mask;
            end
            wr_count = wr_count + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request and completes its response; lat counts cycles from accept edge to resp_valid.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic rfault, output int lat);
        bus.i_req_valid   = 1'b1;
        bus.i_req_write   = wr;
        bus.i_req_funct3  = f3;
        bus.i_req_address = a;
        bus.i_req_data    = d;
        @(posedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        lat = 1;
        while (!bus.o_resp_valid && lat < 10) begin
            @(posedge i_clk); #1;
            lat++;
        end
        rdata  = bus.o_resp_data;
        rfault = bus.o_resp_fault;
        $display("req wr=%0d f3=%03b addr=0x%08h data=0x%08h -> resp=0x%08h fault=%0d lat=%0d",
                 wr, f3, a, d, rdata, rfault, lat);
        bus.i_resp_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.i_resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        rf;
    int          lat;
    int          n;

    initial begin
        bus.i_req_valid   = 1'b0;
        bus.i_req_write   = 1'b0;
        bus.i_req_funct3  = 3'b000;
        bus.i_req_address = '0;
        bus.i_req_data    = '0;
        bus.i_resp_ready  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_req_ready", {31'b0, bus.o_req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, bus.o_resp_valid}, 32'd0);
        chk("rst_resp_data", bus.o_resp_data, 32'd0);
        chk("rst_resp_fault", {31'b0, bus.o_resp_fault}, 32'd0);
        chk("rst_write_en", {31'b0, bus.o_mem_write_en}, 32'd0);
        chk("rst_write_mask", {28'b0, bus.o_mem_write_mask}, 32'd0);
        chk("rst_mem_address", bus.o_mem_address, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // 1: SW then LW, aligned word
        n = wr_count;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, rf, lat);
        chk("sw10_fault", {31'b0, rf}, 32'd0);
        chk("sw10_resp_data", rd, 32'd0);
        chk("sw10_latency", lat, 32'd2);
        chk("sw10_beats", wr_count - n, 32'd1);
        chk("sw10_mask", {28'b0, wr_mask[n]}, 32'hF);
        chk("sw10_addr", wr_addr[n], 32'h10);
        n = wr_count;
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, rf, lat);
        chk("lw10_data", rd, 32'hDEADBEEF);
        chk("lw10_fault", {31'b0, rf}, 32'd0);
        chk("lw10_latency", lat, 32'd2);
        chk("lw10_no_write", wr_count - n, 32'd0);

        // 2: byte/half extraction from 0x81807F01
        do_req(1'b1, 3'b010, 32'h20, 32'h81807F01, rd, rf, lat);
        chk("mem8_init", mem[8], 32'h81807F01);
        do_req(1'b0, 3'b000, 32'h22, 32'h0, rd, rf, lat);
        chk("lb22", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h22, 32'h0, rd, rf, lat);
        chk("lbu22", rd, 32'h00000080);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, rd, rf, lat);
        chk("lh20", rd, 32'h00007F01);
        do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, rf, lat);
        chk("lh22", rd, 32'hFFFF8180);

        // 3: crossing halfword store/load
        n = wr_count;
        do_req(1'b1, 3'b001, 32'h23, 32'h0000ABCD, rd, rf, lat);
        chk("sh23_latency", lat, 32'd3);
        chk("sh23_beats", wr_count - n, 32'd2);
        chk("sh23_b0_addr", wr_addr[n], 32'h20);
        chk("sh23_b0_mask", {28'b0, wr_mask[n]}, 32'h8);
        chk("sh23_b0_lane", {24'b0, wr_data[n][31:24]}, 32'hCD);
        chk("sh23_b1_addr", wr_addr[n+1], 32'h24);
        chk("sh23_b1_mask", {28'b0, wr_mask[n+1]}, 32'h1);
        chk("sh23_b1_lane", {24'b0, wr_data[n+1][7:0]}, 32'hAB);
        chk("sh23_mem8", mem[8], 32'hCD807F01);
        do_req(1'b0, 3'b101, 32'h23, 32'h0, rd, rf, lat);
        chk("lhu23", rd, 32'h0000ABCD);
        chk("lhu23_latency", lat, 32'd3);

        // 4: range faults
        n = wr_count;
        do_req(1'b0, 3'b010, 32'h1000, 32'h0, rd, rf, lat);
        chk("lw1000_fault", {31'b0, rf}, 32'd1);
        chk("lw1000_latency", lat, 32'd1);
        chk("lw1000_data", rd, 32'd0);
        do_req(1'b1, 3'b010, 32'hFFE, 32'h12345678, rd, rf, lat);
        chk("swffe_fault", {31'b0, rf}, 32'd1);
        chk("swffe_latency", lat, 32'd1);
        chk("swffe_no_write", wr_count - n, 32'd0);
        chk("swffe_mem1023", mem[1023], 32'd0);

        // 5: illegal funct3
        do_req(1'b0, 3'b011, 32'h20, 32'h0, rd, rf, lat);
        chk("f3_011_fault", {31'b0, rf}, 32'd1);
        chk("f3_011_data", rd, 32'd0);
        do_req(1'b1, 3'b100, 32'h20, 32'h000000EE, rd, rf, lat);
        chk("sbu_fault", {31'b0, rf}, 32'd1);
        chk("sbu_no_write", wr_count - n, 32'd0);
        chk("sbu_mem8", mem[8], 32'hCD807F01);

        // 6: reset during second beat of a crossing store
        n = wr_count;
        bus.i_req_valid   = 1'b1;
        bus.i_req_write   = 1'b1;
        bus.i_req_funct3  = 3'b010;
        bus.i_req_address = 32'h0E;
        bus.i_req_data    = 32'h11223344;
        @(posedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        chk("swe_b0_we", {31'b0, bus.o_mem_write_en}, 32'd1);
        chk("swe_b0_mask", {28'b0, bus.o_mem_write_mask}, 32'hC);
        @(posedge i_clk); #1;
        chk("swe_b1_mask", {28'b0, bus.o_mem_write_mask}, 32'h3);
        chk("swe_b1_addr", bus.o_mem_address, 32'h10);
        i_rst = 1'b1;
        #1;
        chk("swe_rst_we_gated", {31'b0, bus.o_mem_write_en}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("swe_idle_ready", {31'b0, bus.o_req_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            chk("swe_no_resp", {31'b0, bus.o_resp_valid}, 32'd0);
            @(posedge i_clk); #1;
        end
        chk("swe_one_beat", wr_count - n, 32'd1);
        chk("swe_mem3_hi", {16'b0, mem[3][31:16]}, 32'h3344);
        chk("swe_mem4_kept", mem[4], 32'hDEADBEEF);
        $display("reset-abort SW @0x0E: beats=%0d mem3=0x%08h mem4=0x%08h", wr_count - n, mem[3], mem[4]);

        // Response held stable while i_resp_ready stays low
        bus.i_req_valid   = 1'b1;
        bus.i_req_write   = 1'b0;
        bus.i_req_funct3  = 3'b010;
        bus.i_req_address = 32'h20;
        @(posedge i_clk); #1;
        bus.i_req_valid = 1'b0;
        @(posedge i_clk); #1;
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", {31'b0, bus.o_resp_valid}, 32'd1);
            chk("hold_data", bus.o_resp_data, 32'hCD807F01);
            chk("hold_not_ready", {31'b0, bus.o_req_ready}, 32'd0);
            @(posedge i_clk); #1;
        end
        bus.i_resp_ready = 1'b1;
        @(posedge i_clk); #1;
        bus.i_resp_ready = 1'b0;
        chk("hold_released", {31'b0, bus.o_resp_valid}, 32'd0);
        chk("hold_idle_ready", {31'b0, bus.o_req_ready}, 32'd1);
        $display("held LW @0x20 released after 3 stalled cycles");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
